// File: rtl/led_pkg.sv
// Shared definitions for the LED arbiter: state encoding used by led_arb.
package led_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t GRANT = 2'd1;
  localparam state_t BLANK = 2'd2;

endpackage

// File: rtl/led_arb_if.sv
// LED arbiter bus: timebase, requests and patterns in; grant, LEDs and busy out.
interface led_arb_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);

  logic                    tick;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   pat;
  logic [NREQ-1:0]         gnt;
  logic [WIDTH-1:0]        leds;
  logic                    busy;

  // Requester side drives requests and patterns, arbiter side answers.
  modport master (output tick, req, pat, input gnt, leds, busy);
  modport slave  (input tick, req, pat, output gnt, leds, busy);

endinterface

// File: rtl/led_arb_rr_pick.sv
// Combinational round-robin picker: first set request above the last-granted
// index, wrapping; the last-granted index itself is checked last.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_win,
  output logic            o_valid
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  assign o_valid = |i_req;

  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    o_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      w_idx = IW'((int'(i_last) + off) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        o_win[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arb.sv
// Round-robin LED arbiter with min/max grant hold in ticks.
// Define LED_ARB_BLANK_EN to insert a one-tick blank period after every grant.
module led_arb
  import led_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MIN_TICKS = 2,
  parameter int MAX_TICKS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] pat,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      leds,
  output logic                  busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_TICKS + 1);

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [WIDTH-1:0] r_leds;
  logic [HW-1:0]   r_hold;
  logic [IW-1:0]   r_last;

  logic [NREQ-1:0] w_win;
  logic            w_valid;
  logic [IW-1:0]   w_win_idx;
  logic [WIDTH-1:0] w_pat_arr [NREQ];
  logic [WIDTH-1:0] w_pat_own;
  logic            w_own_req;
  logic            w_others;
  logic            w_release;
  logic            w_preempt;
  logic            w_end;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .i_req   (req),
    .i_last  (r_last),
    .o_win   (w_win),
    .o_valid (w_valid)
  );

  for (genvar k = 0; k < NREQ; k++) begin : g_pat
    assign w_pat_arr[k] = pat[k*WIDTH +: WIDTH];
  end

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) w_win_idx = IW'(i);
    end
  end

  // While granting, r_last is the owner's index.
  assign w_pat_own = w_pat_arr[r_last];
  assign w_own_req = req[r_last];
  assign w_others  = |(req & ~r_gnt);
  assign w_release = (r_hold >= HW'(MIN_TICKS)) && !w_own_req;
  assign w_preempt = (r_hold == HW'(MAX_TICKS)) && w_others;
  assign w_end     = w_release || w_preempt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
      r_state <= IDLE;
      r_gnt   <= '0;
      r_leds  <= '0;
      r_hold  <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          r_leds <= '0;
          if (w_valid) begin
            r_state <= GRANT;
            r_gnt   <= w_win;
            r_last  <= w_win_idx;
            r_hold  <= '0;
          end
        end
        GRANT: begin
          if (w_end) begin
            // A tick on this edge is dropped: the next owner starts at zero.
            r_hold <= '0;
            r_leds <= '0;
`ifdef LED_ARB_BLANK_EN
            r_state <= BLANK;
            r_gnt   <= '0;
`else
            if (w_valid) begin
              r_gnt  <= w_win;
              r_last <= w_win_idx;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
`endif
          end else begin
            r_leds <= w_pat_own;
            if (tick && (r_hold != HW'(MAX_TICKS))) r_hold <= r_hold + 1'b1;
          end
        end
`ifdef LED_ARB_BLANK_EN
        BLANK: begin
          r_leds <= '0;
          if (tick) begin
            if (w_valid) begin
              r_state <= GRANT;
              r_gnt   <= w_win;
              r_last  <= w_win_idx;
              r_hold  <= '0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
`endif
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_leds  <= '0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign leds = r_leds;
  assign busy = |r_gnt;

endmodule

// File: doc/led_arb.md
LED_ARB -- requirements
Module: led_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter WIDTH SHALL default to 8 and set the LED bus width.
REQ-003 Parameter NREQ SHALL default to 4 and set the requester count (2..8).
REQ-004 Parameter MIN_TICKS SHALL default to 2 and set the minimum grant hold in ticks (>=1).
REQ-005 Parameter MAX_TICKS SHALL default to 4 and set the maximum grant hold in ticks when contended (>=MIN_TICKS).
REQ-006 Ports SHALL be, one per line:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- tick  in  1  one-clk timebase pulse from the cnt prescaler
- req  in  NREQ  per-requester level request
- pat  in  NREQ*WIDTH  per-requester LED pattern; slice k = pat[k*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- leds  out  WIDTH  registered LED drive
- busy  out  1  high while any grant is held

Function
REQ-007 States SHALL be IDLE, GRANT and BLANK; BLANK exists only per REQ-020.
REQ-008 IDLE: gnt=0, leds=0, busy=0; if any req bit is set, the next edge enters GRANT with gnt one-hot for the winner.
REQ-009 The winner SHALL be chosen round-robin: first set req bit scanning upward from (last granted index + 1) mod NREQ; after reset the scan starts at index 0.
REQ-010 In GRANT, leds SHALL equal pat slice of the granted index sampled each clk, giving 1-cycle latency from pat to leds.
REQ-011 hold_cnt SHALL clear on grant entry and increment on each tick in GRANT, saturating at MAX_TICKS.
REQ-012 Release: when hold_cnt>=MIN_TICKS and the granted req bit is low, the grant SHALL end at the next edge.
REQ-013 Preempt: when hold_cnt==MAX_TICKS and any other req bit is high, the grant SHALL end at the next edge even if the owner still requests.
REQ-014 With no other requester pending, the owner SHALL keep the grant indefinitely while its req stays high.
REQ-015 If the owner drops req before MIN_TICKS, gnt SHALL be held and leds SHALL keep showing its current pat until MIN_TICKS, then release.
REQ-016 On grant end without BLANK, a pending requester SHALL be granted in the same edge (no idle cycle); otherwise the next state is IDLE.
REQ-017 A tick coincident with a release or preempt edge SHALL NOT be counted for the next owner.
REQ-018 busy SHALL equal |gnt.

Reset
REQ-019 rst_n low at any edge, including mid-grant, SHALL force IDLE, gnt=0, leds=0, busy=0, hold_cnt=0 and round-robin pointer=NREQ-1 (so the scan starts at 0).

Configuration
REQ-020 With LED_ARB_BLANK_EN defined, every grant end SHALL pass through BLANK (gnt=0, leds=0, busy=0) for exactly one tick period, i.e. until the next tick, and then arbitrate as in IDLE; without it, the handover follows REQ-016 and BLANK is not synthesised.

Structure
REQ-021 The state encoding localparams (IDLE=2'd0, GRANT=2'd1, BLANK=2'd2) SHALL live in shared package led_pkg.
REQ-022 Round-robin selection SHALL be a sub-module rr_pick (inputs req and last-granted index; output one-hot winner and any-valid flag), purely combinational.
REQ-023 The implementation SHALL be 120-400 lines of RTL in total.

Verification (WIDTH=8, NREQ=4, MIN_TICKS=2, MAX_TICKS=4, tick every 5 clk)
REQ-024 After reset, req=4'b0100 and pat[2]=8'hA5 -> gnt=4'b0100 one edge later, then leds=8'hA5 one edge after that, busy=1.
REQ-025 req=4'b1111 held -> grants rotate 0,1,2,3,0, each held 4 ticks (20 clk).
REQ-026 Owner 1 drops req after 1 tick with req[3]=1 -> gnt stays 4'b0010 until the 2nd tick, then 4'b1000 on the next edge.
REQ-027 Sole requester 0 held for 50 ticks -> gnt stays 4'b0001, no preemption.
REQ-028 rst_n=0 for one edge mid-grant of requester 2 -> gnt=0 and leds=0 the next cycle; with req=4'b0101 the next grant is index 0.
REQ-029 With LED_ARB_BLANK_EN, handover from 0 to 1 -> leds=0 and gnt=0 from the release edge until the next tick, then gnt=4'b0010.
